y86_instr_encoder: RTL
======================

# y86_instr_encoder

Serialising encoder for the Y86-64 instruction memory, the write-side counterpart of the fetch stage. It accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and emits its encoded bytes, one per cycle, with byte addresses for instruction-memory writes. The byte layout is exactly the layout the fetch stage decodes, so programs loaded by this block fetch back bit-identical. It is used by the program loader and by testbenches that fill instruction memory.

## Interface
- MEM_BYTES, 1024: instruction memory size in bytes; address width is clog2(MEM_BYTES)=10.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- addr_load  in  1  load write pointer from addr_base; honoured in IDLE only.
- addr_base  in  10  new write pointer.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept; high only in IDLE.
- in_icode, in_ifun, in_rA, in_rB  in  4 each  instruction fields.
- in_valC  in  64  constant word.
- out_valid  out  1  out_byte/out_addr valid.
- out_ready  in  1  memory accepts the byte.
- out_addr  out  10  byte address.
- out_byte  out  8  encoded byte.
- out_last  out  1  final byte of the current instruction.
- wr_ptr  out  10  next free address.
- err_invalid  out  1  sticky: icode > 0xB was offered.
- err_range  out  1  sticky: instruction would cross MEM_BYTES.

## Operation
- Length by icode: 0 halt, 1 nop, 9 ret → 1; 2 cmovXX, 6 OPq, A pushq, B popq → 2; 7 jXX, 8 call → 9; 3 irmovq, 4 rmmovq, 5 mrmovq → 10; C–F invalid.
- Byte 0 = {icode, ifun}. Lengths 2 and 10: byte 1 = {rA, rB}. Length 10: bytes 2..9 = valC[63:56] … valC[7:0] (MSB first). Length 9: bytes 1..8 = valC MSB first. rA/rB/valC are not emitted for instructions that have no such field. ifun is emitted unchecked.
- FSM IDLE: in_ready=1 unless addr_load=1. addr_load has priority: wr_ptr←addr_base and the instruction is not accepted that cycle. On in_valid&in_ready: an invalid icode sets err_invalid; if wr_ptr+len > MEM_BYTES, err_range is set. In either error case the instruction is consumed, no bytes are emitted, wr_ptr is unchanged, and the FSM stays in IDLE. Otherwise the 80-bit left-aligned image, len, and cnt=0 are latched and the FSM goes to EMIT.
- FSM EMIT: out_valid=1, out_byte=image[79:72], out_addr=wr_ptr, out_last=(cnt==len-1). On out_ready the image shifts left 8, wr_ptr+1, cnt+1. If out_last, go to IDLE. addr_load and in_valid are ignored in EMIT.
- wr_ptr arithmetic is 10-bit. The range check prevents wrap; the check is computed in 11 bits.
- Error flags clear only on reset.

## Timing
- Reset values: FSM IDLE, wr_ptr 0, out_valid 0, out_byte 0, out_addr 0, out_last 0, err_invalid 0, err_range 0. in_ready is 0 while reset is asserted.
- Acceptance edge → out_valid high on the next cycle. The first byte is presented one cycle after the handshake.
- Without backpressure, an instruction of length L occupies L+1 cycles: 1 accept plus L emit. in_ready is low for L cycles.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset mid-EMIT aborts the instruction. Bytes already written remain in memory; wr_ptr returns to 0.

## Structure
- The shared package y86_pkg holds:
  - icode constants (I_HALT … I_POPQ);
  - register-ID constant R_NONE=4'hF;
  - MEM_BYTES;
  - the function instr_len(icode) returning {valid, len[3:0]}.
- The fetch stage reuses the same package for its length decode.
- One sub-module, y86_instr_len, is a combinational lookup from icode to valid and length; the FSM/datapath lives in the top.

## Test plan
- irmovq $0x11,%rbx (3,0,F,3,valC=0x11) at addr_base=10, out_ready=1 → bytes 30 F3 00 00 00 00 00 00 00 11 at addresses 10..19; out_last only at 19; wr_ptr=20.
- Back-to-back OPq 6/0 rA=2 rB=0, then ret → 60 20 @20–21, 90 @22; in_ready low exactly 2 cycles, then 1 cycle.
- jXX icode 7 valC=0x0102030405060708, out_ready toggling 1-0-1 → bytes 70 01 02 … 08 (9 bytes), each held while stalled, no duplicates or drops.
- icode 0xC offered → err_invalid=1, no out_valid, wr_ptr unchanged; a following nop still encodes as 10.
- addr_base=1020, then irmovq → err_range=1, no bytes; nop at 1020 → emits 10 @1020, wr_ptr=1021.
- Reset asserted on the 4th byte of rmmovq → next cycle out_valid=0, wr_ptr=0, errors 0, FSM IDLE, in_ready=1 once reset is released.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, register IDs, memory size
// and the instruction length decode used by fetch and encoder.
package y86_pkg;

  localparam int MEM_BYTES = 1024;
  localparam int AW        = $clog2(MEM_BYTES);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } enc_state_e;

  // Returns {valid, len}; len is 0 for unknown icodes.
  function automatic logic [4:0] instr_len(input logic [3:0] icode);
    logic [4:0] r;
    case (icode)
      I_HALT, I_NOP, I_RET:                 r = {1'b1, 4'd1};
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:     r = {1'b1, 4'd2};
      I_JXX, I_CALL:                        r = {1'b1, 4'd9};
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         r = {1'b1, 4'd10};
      default:                              r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode -> {valid, length} lookup.
// Thin wrapper so the decode is a visible block in the hierarchy.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       valid_o,
  output logic [3:0] len_o
);

  // Table lookup shared with the fetch stage
  always_comb begin
    {valid_o, len_o} = instr_len(icode_i);
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialising Y86-64 instruction encoder: one instruction in,
// its bytes out one per cycle with instruction-memory addresses.
module y86_instr_encoder
  import y86_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          addr_load,
  input  logic [AW-1:0] addr_base,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_icode,
  input  logic [3:0]    in_ifun,
  input  logic [3:0]    in_rA,
  input  logic [3:0]    in_rB,
  input  logic [63:0]   in_valC,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [7:0]    out_byte,
  output logic          out_last,
  output logic [AW-1:0] wr_ptr,
  output logic          err_invalid,
  output logic          err_range
);

  enc_state_e    state_q, state_d;
  logic [79:0]   img_q, img_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          einv_q, einv_d;
  logic          erng_q, erng_d;

  logic          len_vld;
  logic [3:0]    len;
  logic [79:0]   image;
  logic [AW:0]   end_sum;
  logic          emit;
  logic          last;

  y86_instr_len u_len (
    .icode_i (in_icode),
    .valid_o (len_vld),
    .len_o   (len)
  );

  // Left-aligned byte image; fields absent from the format are dropped
  always_comb begin
    image = {in_icode, in_ifun, 72'h0};
    case (len)
      4'd2:    image = {in_icode, in_ifun, in_rA, in_rB, 64'h0};
      4'd9:    image = {in_icode, in_ifun, in_valC, 8'h0};
      4'd10:   image = {in_icode, in_ifun, in_rA, in_rB, in_valC};
      default: image = {in_icode, in_ifun, 72'h0};
    endcase
  end

  assign end_sum = (AW+1)'(ptr_q) + (AW+1)'(len);
  assign emit    = (state_q == S_EMIT);
  assign last    = emit && (cnt_q == len_q - 4'd1);

  assign in_ready    = !reset && (state_q == S_IDLE) && !addr_load;
  assign out_valid   = emit;
  assign out_byte    = emit ? img_q[79:72] : 8'h00;
  assign out_addr    = emit ? ptr_q : '0;
  assign out_last    = last;
  assign wr_ptr      = ptr_q;
  assign err_invalid = einv_q;
  assign err_range   = erng_q;

  // Next-state: accept/reject in IDLE, shift bytes out in EMIT
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    einv_d  = einv_q;
    erng_d  = erng_q;
    case (state_q)
      S_IDLE: begin
        if (addr_load) begin
          ptr_d = addr_base;
        end else if (in_valid) begin
          if (!len_vld) begin
            einv_d = 1'b1;
          end else if (end_sum > (AW+1)'(MEM_BYTES)) begin
            erng_d = 1'b1;
          end else begin
            img_d   = image;
            len_d   = len;
            cnt_d   = 4'd0;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          img_d = {img_q[71:0], 8'h00};
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q + 4'd1;
          if (last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      img_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      einv_q  <= 1'b0;
      erng_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      einv_q  <= einv_d;
      erng_q  <= erng_d;
    end
  end

endmodule
